data_storage_system: RTL and testbench
======================================

// Module: data_storage_system
// PURPOSE
//   Small addressable data store: 4 words x 8 bits behind a single-port write/read interface.
//   Consists of an address decoder, a bank of word registers and a registered read multiplexer.
//   Serves as the top-level of the storage subsystem.
//   Driven directly by a host that presents address, data and a write strobe each cycle.
// PARAMETERS
//   DATA_W  8  width of each stored word and of d/q
//   ADDR_W  2  address width; depth = 2**ADDR_W (4 words)
// PORTS
//   clk   in   1       single clock; all state updates on rising edge
//   rst   in   1       asynchronous, active-low reset (0 = reset asserted)
//   wr    in   1       write enable; 1 = write d into word[addr] on this edge
//   d     in   DATA_W  write data
//   addr  in   ADDR_W  word select for both write and read
//   q     out  DATA_W  registered read data
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low.
//   - Reset (rst=0, any time, no clock needed):
//     - all words clear to 0;
//     - q clears to 0.
//     - Held while rst=0.
//     - Mid-operation reset discards any write in progress.
//   - Reset release is sampled synchronously; first active edge is the first rising clk with rst=1.
//   - Write: on rising clk with rst=1 and wr=1, word[addr] <= d.
//     - Exactly one word changes per write; others hold.
//   - wr=0: no word changes; d is ignored.
//   - Read: every rising clk with rst=1, q <= word[addr] (1-cycle latency, regardless of wr).
//   - Read-during-write to the same addr: write-first, so q <= d on that same edge.
//   - addr/d/wr may change every cycle; no handshake, no busy state, no FSM.
//   - All addr values 0..3 are valid; no out-of-range case; no wrap logic needed.
//   - d wider than needed at the driver is the driver's concern; the block stores exactly DATA_W bits.
//   - No X propagation: all storage has a defined reset value.
// TESTING
//   1. Hold rst=0, toggle clk, wr=1, d=8'hFF:
//      -> q=8'h00 and no word written; assert rst=0 between edges -> q drops to 0 immediately.
//   2. Release rst; addr=0, d=8'h01, wr=1 for one edge:
//      -> q=8'h01 after that edge (write-first).
//      -> Then wr=0 -> q stays 8'h01.
//   3. Write 8'hA0,8'hB1,8'hC2,8'hD3 to addr 0..3, then wr=0 and read addr 0..3:
//      -> q = A0,B1,C2,D3, each one edge after addr is applied.
//   4. wr=0, addr=2, d=8'h55 for several edges:
//      -> word2 unchanged; q=8'hC2.
//   5. Back-to-back writes to addr=1 (8'h11 then 8'h22):
//      -> q=11 then 22; addr 0/2/3 read back unchanged.
//   6. Pulse rst=0 asynchronously after step 3:
//      -> q=0 at once; all four addresses read 8'h00 after release.

Source files
------------

// File: rtl/data_storage_system.sv
`default_nettype none
// ============================================================================
// Module      : data_storage_system
// Description : Four-word (2**ADDR_W x DATA_W) addressable data store. An
//               address decoder selects one word register for writing, and
//               a registered read multiplexer returns word[addr] one clock
//               later. A read of the word being written returns the new data.
// Ports       : clk  - single clock, rising-edge active
//               rst  - asynchronous reset, active low (0 = reset)
//               wr   - write enable; writes d into word[addr]
//               d    - write data (DATA_W bits)
//               addr - word select for both write and read (ADDR_W bits)
//               q    - registered read data (DATA_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module data_storage_system #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // One-hot write select produced by the address decoder.
    logic [c_DEPTH-1:0] w_wr_sel;
    logic [DATA_W-1:0]  w_rd_data;
    logic [DATA_W-1:0]  r_word [c_DEPTH];
    logic [DATA_W-1:0]  r_q;

    generate
        for (genvar i = 0; i < c_DEPTH; i++) begin : g_dec
            assign w_wr_sel[i] = wr && (addr == ADDR_W'(i));
        end
    endgenerate

    // Word bank: only the decoded word loads; every other word holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_word[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (w_wr_sel[i]) begin
                    r_word[i] <= d;
                end
            end
        end
    end

    // Write-first read path: the read and write address are the same port,
    // so any write implies the read targets the word being written, and the
    // incoming data bypasses the not-yet-updated register.
    always_comb begin
        w_rd_data = r_word[addr];
        if (wr) begin
            w_rd_data = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_rd_data;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: tb/tb_data_storage_system.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_storage_system
// Description : Directed self-checking bench for data_storage_system.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_storage_system;

    logic       clk;
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic [1:0] addr;
    logic [7:0] q;

    int n_checks;
    int n_fail;

    data_storage_system #(
        .DATA_W(8),
        .ADDR_W(2)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr),
        .d    (d),
        .addr (addr),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_rd [4];
        exp_rd = '{8'h00, 8'h00, 8'h00, 8'h00};
        rst  = 1'b1;
        wr   = 1'b1;
        d    = 8'hFF;
        addr = 2'd0;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async q=%h expected=%h", q, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            tick();
            n_checks++;
            if (q !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_held edge%0d q=%h expected=%h", i, q, 8'h00);
            end
        end
        // Release between edges; no write happened during reset.
        wr  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            tick();
            n_checks++;
            if (q !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL reset_words addr%0d q=%h expected=%h", i, q, exp_rd[i]);
            end
        end
    endtask

    task automatic test_first_write();
        addr = 2'd0;
        d    = 8'h01;
        wr   = 1'b1;
        tick();
        n_checks++;
        if (q !== 8'h01) begin
            n_fail++;
            $display("FAIL first_write q=%h expected=%h", q, 8'h01);
        end
        wr = 1'b0;
        d  = 8'h99;
        tick();
        n_checks++;
        if (q !== 8'h01) begin
            n_fail++;
            $display("FAIL first_hold q=%h expected=%h", q, 8'h01);
        end
    endtask

    task automatic test_fill_read();
        logic [7:0] vals [4];
        vals = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            d    = vals[i];
            wr   = 1'b1;
            tick();
            n_checks++;
            if (q !== vals[i]) begin
                n_fail++;
                $display("FAIL fill_wfirst addr%0d q=%h expected=%h", i, q, vals[i]);
            end
        end
        wr = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            tick();
            n_checks++;
            if (q !== vals[i]) begin
                n_fail++;
                $display("FAIL fill_read addr%0d q=%h expected=%h", i, q, vals[i]);
            end
        end
    endtask

    task automatic test_no_write();
        wr   = 1'b0;
        addr = 2'd2;
        d    = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== 8'hC2) begin
                n_fail++;
                $display("FAIL no_write edge%0d q=%h expected=%h", i, q, 8'hC2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rd [4];
        exp_rd = '{8'hA0, 8'h22, 8'hC2, 8'hD3};
        addr = 2'd1;
        wr   = 1'b1;
        d    = 8'h11;
        tick();
        n_checks++;
        if (q !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_first q=%h expected=%h", q, 8'h11);
        end
        d = 8'h22;
        tick();
        n_checks++;
        if (q !== 8'h22) begin
            n_fail++;
            $display("FAIL b2b_second q=%h expected=%h", q, 8'h22);
        end
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            tick();
            n_checks++;
            if (q !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL b2b_read addr%0d q=%h expected=%h", i, q, exp_rd[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        // q currently holds D3 from the last read of addr 3.
        n_checks++;
        if (q !== 8'hD3) begin
            n_fail++;
            $display("FAIL areset_pre q=%h expected=%h", q, 8'hD3);
        end
        // Write in progress when reset hits; it must be discarded.
        addr = 2'd0;
        d    = 8'h77;
        wr   = 1'b1;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_now q=%h expected=%h", q, 8'h00);
        end
        tick();
        n_checks++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_held q=%h expected=%h", q, 8'h00);
        end
        wr  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            tick();
            n_checks++;
            if (q !== 8'h00) begin
                n_fail++;
                $display("FAIL areset_read addr%0d q=%h expected=%h", i, q, 8'h00);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_first_write();
        test_fill_read();
        test_no_write();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
